if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: fetch address after reset.
REQ-002 Parameter NOP_INST, default 32'h0000_0013 (addi x0,x0,0): instruction presented when IF/ID is empty.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 stall  input  1  hazard unit holds IF/ID contents and PC.
REQ-006 redirect_valid  input  1  taken branch/jump from EX; squash and refetch.
REQ-007 redirect_pc  input  32  new fetch address when redirect_valid=1.
REQ-008 imem_req  output  1  instruction read request, level-held until imem_ack.
REQ-009 imem_addr  output  32  word address of request; stable while imem_req=1 and imem_ack=0.
REQ-010 imem_ack  input  1  read data valid this cycle (same cycle as req or later).
REQ-011 imem_rdata  input  32  instruction word, sampled only when imem_ack=1.
REQ-012 if_id_valid  output  1  IF/ID holds a live instruction.
REQ-013 if_id_pc  output  32  PC of if_id_inst.
REQ-014 if_id_pc4  output  32  if_id_pc+4, modulo 2^32.
REQ-015 if_id_inst  output  32  instruction to the decode/control stage; NOP_INST when if_id_valid=0.
REQ-016 misaligned  output  1  one-cycle pulse: accepted redirect_pc[1:0]!=0.

Function
REQ-017 States SHALL be FETCH, HOLD, DISCARD; at most one imem request outstanding.
REQ-018 FETCH: imem_req=1, imem_addr=pc.
REQ-019 FETCH, ack=1, stall=0, no redirect: IF/ID <= {1, pc, pc+4, imem_rdata}; pc <= pc+4; stay FETCH.
REQ-020 FETCH, ack=1, stall=1, no redirect: instruction captured in 1-entry buffer with its pc; IF/ID unchanged; -> HOLD.
REQ-021 FETCH, ack=0, stall=1: IF/ID unchanged; request stays pending.
REQ-022 HOLD: imem_req=0; while stall=1 IF/ID and buffer unchanged; when stall=0, IF/ID <= buffer, pc <= buffered pc+4, -> FETCH.
REQ-023 redirect_valid=1 in any state: pc <= {redirect_pc[31:2],2'b00}; if_id_valid <= 0; if_id_inst <= NOP_INST; buffer dropped; redirect overrides stall.
REQ-024 Redirect in FETCH with ack=0: -> DISCARD (pending request must complete at its old address); otherwise -> FETCH.
REQ-025 DISCARD: imem_req=1, imem_addr = old address; on ack data discarded, -> FETCH at redirected pc; a further redirect in DISCARD updates pc only.
REQ-026 Redirect with ack=1 in FETCH: returned data discarded; -> FETCH next cycle at redirect target.
REQ-027 misaligned SHALL pulse for the cycle following acceptance of a redirect with redirect_pc[1:0]!=0; otherwise 0.
REQ-028 pc+4 SHALL wrap: 32'hFFFF_FFFC -> 32'h0000_0000; if_id_pc4 wraps identically.
REQ-029 Outputs SHALL be registered except imem_req/imem_addr (decoded from state and pc).
REQ-030 if_id_valid=0 SHALL force if_id_inst=NOP_INST so downstream decode yields no register/memory writes.

Reset
REQ-031 rst=1 SHALL immediately force: state FETCH, pc=RESET_PC, if_id_valid=0, if_id_pc=0, if_id_pc4=0, if_id_inst=NOP_INST, misaligned=0, buffer empty, imem_req=0 while rst=1.
REQ-032 First rising edge after rst falls: imem_req=1, imem_addr=RESET_PC.
REQ-033 rst asserted mid-request or in HOLD/DISCARD SHALL abandon all state; late imem_ack after reset is ignored until imem_req reasserts.

Verification
REQ-034 Reset release, ack every cycle, rdata=32'h00500093,32'h00A00113 -> if_id_pc 0 then 4, if_id_pc4 4 then 8, insts in order, valid=1.
REQ-035 ack delayed 3 cycles on addr 8 -> imem_addr held 8, IF/ID unchanged, after ack if_id_pc=8.
REQ-036 stall=1 with ack on addr 12 -> HOLD, imem_req=0, IF/ID still shows pc 8; stall=0 -> if_id_pc=12, next imem_addr=16.
REQ-037 redirect_valid=1, redirect_pc=32'h100 while addr 16 pending ack=0 -> if_id_valid=0, inst=32'h00000013, req held at 16, its data dropped, next request addr 32'h100.
REQ-038 redirect_pc=32'h202 together with stall=1 -> redirect wins, misaligned=1 one cycle, fetch addr 32'h200.
REQ-039 pc=32'hFFFF_FFFC fetched -> if_id_pc4=0, next imem_addr=0.

Source files
------------

// File: rtl/if_stage.sv
// Instruction fetch stage: drives a single-outstanding instruction memory
// request, fills the IF/ID pipeline register, parks one fetched word while
// decode is stalled, and squashes/refetches on redirects from EX.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_id_valid,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc4,
  output logic [31:0] if_id_inst,
  output logic        misaligned
);

  // FETCH   : request outstanding at pc
  // HOLD    : one fetched word parked in the buffer, waiting for stall to drop
  // DISCARD : request at old_addr still in flight but its data is unwanted
  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t      state;
  // Low for the first cycle after reset so no request is raised while rst is
  // high and any acknowledge left over from before the reset is ignored.
  logic        running;
  logic [31:0] pc;
  logic [31:0] old_addr;
  logic [31:0] buf_pc;
  logic [31:0] buf_inst;

  logic [31:0] pc_plus4;
  logic [31:0] buf_pc_plus4;
  logic [31:0] redirect_target;
  logic        fetch_accept;

  assign pc_plus4        = pc + 32'd4;
  assign buf_pc_plus4    = buf_pc + 32'd4;
  assign redirect_target = {redirect_pc[31:2], 2'b00};

  // Request is a pure decode of state; the address only differs from pc
  // while draining a squashed request, which must finish at its old address.
  assign imem_req  = running && (state != HOLD);
  assign imem_addr = (state == DISCARD) ? old_addr : pc;

  // A returned word is only meaningful when we actually asked for it.
  assign fetch_accept = imem_req && imem_ack;

  // Fetch control FSM with IF/ID register, parking buffer and misaligned flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= FETCH;
      running     <= 1'b0;
      pc          <= RESET_PC;
      old_addr    <= RESET_PC;
      buf_pc      <= 32'd0;
      buf_inst    <= NOP_INST;
      if_id_valid <= 1'b0;
      if_id_pc    <= 32'd0;
      if_id_pc4   <= 32'd0;
      if_id_inst  <= NOP_INST;
      misaligned  <= 1'b0;
    end else begin
      running    <= 1'b1;
      misaligned <= 1'b0;
      if (redirect_valid) begin
        // Redirect beats stall and everything else: squash IF/ID, drop any
        // parked word, and start over at the word-aligned target.
        pc          <= redirect_target;
        if_id_valid <= 1'b0;
        if_id_inst  <= NOP_INST;
        misaligned  <= |redirect_pc[1:0];
        if (imem_req && !imem_ack) begin
          // The memory still owes us a word; remember where it was asked
          // for so the request stays stable until it completes.
          state    <= DISCARD;
          old_addr <= imem_addr;
        end else begin
          state <= FETCH;
        end
      end else begin
        case (state)
          FETCH: begin
            if (fetch_accept) begin
              if (stall) begin
                buf_pc   <= pc;
                buf_inst <= imem_rdata;
                state    <= HOLD;
              end else begin
                if_id_valid <= 1'b1;
                if_id_pc    <= pc;
                if_id_pc4   <= pc_plus4;
                if_id_inst  <= imem_rdata;
                pc          <= pc_plus4;
              end
            end
          end
          HOLD: begin
            if (!stall) begin
              if_id_valid <= 1'b1;
              if_id_pc    <= buf_pc;
              if_id_pc4   <= buf_pc_plus4;
              if_id_inst  <= buf_inst;
              pc          <= buf_pc_plus4;
              state       <= FETCH;
            end
          end
          DISCARD: begin
            // Stale data is thrown away; pc already holds the new target.
            if (imem_ack) begin
              state <= FETCH;
            end
          end
          default: begin
            state <= FETCH;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed sequences with literal expectations, then
// randomized stimulus compared every cycle against a behavioural model.
module tb_if_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc4;
  logic [31:0] if_id_inst;
  logic        misaligned;

  int checks   = 0;
  int failures = 0;

  if_stage #(
    .RESET_PC(32'h0000_0000),
    .NOP_INST(NOP)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .if_id_valid   (if_id_valid),
    .if_id_pc      (if_id_pc),
    .if_id_pc4     (if_id_pc4),
    .if_id_inst    (if_id_inst),
    .misaligned    (misaligned)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%08h required=%08h", name, $time, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%0b required=%0b", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  entry_t      held_q[$];
  bit          m_started      = 1'b0;
  logic [31:0] m_pc           = 32'h0;
  bit          m_doomed       = 1'b0;
  logic [31:0] m_doomed_addr  = 32'h0;
  bit          m_valid        = 1'b0;
  logic [31:0] m_ifpc         = 32'h0;
  logic [31:0] m_ifpc4        = 32'h0;
  logic [31:0] m_inst         = NOP;
  bit          m_mis          = 1'b0;
  bit          s_req;
  logic [31:0] s_addr;
  entry_t      s_e;

  // Model: a request is open whenever started and nothing is parked; an
  // acknowledged word is delivered, parked, or dropped if it was squashed.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      held_q.delete();
      m_started = 1'b0;
      m_pc      = 32'h0;
      m_doomed  = 1'b0;
      m_valid   = 1'b0;
      m_ifpc    = 32'h0;
      m_ifpc4   = 32'h0;
      m_inst    = NOP;
      m_mis     = 1'b0;
    end else begin
      s_req     = m_started && (held_q.size() == 0);
      s_addr    = m_doomed ? m_doomed_addr : m_pc;
      m_started = 1'b1;
      if (redirect_valid) begin
        m_doomed      = s_req && !imem_ack;
        m_doomed_addr = s_addr;
        held_q.delete();
        m_mis   = (redirect_pc % 4) != 0;
        m_pc    = redirect_pc - (redirect_pc % 4);
        m_valid = 1'b0;
        m_inst  = NOP;
      end else begin
        m_mis = 1'b0;
        if (m_doomed) begin
          if (s_req && imem_ack) m_doomed = 1'b0;
        end else if (held_q.size() != 0) begin
          if (!stall) begin
            s_e     = held_q.pop_front();
            m_valid = 1'b1;
            m_ifpc  = s_e.pc;
            m_ifpc4 = s_e.pc + 32'd4;
            m_inst  = s_e.inst;
            m_pc    = s_e.pc + 32'd4;
          end
        end else if (s_req && imem_ack) begin
          if (stall) begin
            held_q.push_back('{pc: m_pc, inst: imem_rdata});
          end else begin
            m_valid = 1'b1;
            m_ifpc  = m_pc;
            m_ifpc4 = m_pc + 32'd4;
            m_inst  = imem_rdata;
            m_pc    = m_pc + 32'd4;
          end
        end
      end
    end
  end

  // Compare DUT outputs to the model once per cycle, away from the clock edge.
  always @(negedge clk) begin
    bit          ereq;
    logic [31:0] eaddr;
    ereq  = m_started && (held_q.size() == 0);
    eaddr = m_doomed ? m_doomed_addr : m_pc;
    chk1("model_imem_req", imem_req, ereq);
    if (ereq) chk32("model_imem_addr", imem_addr, eaddr);
    chk1("model_if_id_valid", if_id_valid, m_valid);
    chk32("model_if_id_pc", if_id_pc, m_ifpc);
    chk32("model_if_id_pc4", if_id_pc4, m_ifpc4);
    chk32("model_if_id_inst", if_id_inst, m_inst);
    chk1("model_misaligned", misaligned, m_mis);
  end

  // One clock of stimulus; returns just after the rising edge.
  task automatic cycle(input logic s, input logic rv, input logic [31:0] rp,
                       input logic a, input logic [31:0] d);
    @(negedge clk);
    #1;
    stall          = s;
    redirect_valid = rv;
    redirect_pc    = rp;
    imem_ack       = a;
    imem_rdata     = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst            = 1'b1;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    imem_ack       = 1'b0;
    imem_rdata     = 32'h0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk1("rst_req", imem_req, 1'b0);
    chk1("rst_valid", if_id_valid, 1'b0);
    chk32("rst_pc", if_id_pc, 32'h0);
    chk32("rst_pc4", if_id_pc4, 32'h0);
    chk32("rst_inst", if_id_inst, NOP);
    chk1("rst_mis", misaligned, 1'b0);

    // First edge after release raises the request at RESET_PC
    @(negedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk1("first_req", imem_req, 1'b1);
    chk32("first_addr", imem_addr, 32'h0);
    $display("txn reset_release req=%0b addr=%08h", imem_req, imem_addr);

    // Back-to-back fetches
    cycle(0, 0, 0, 1, 32'h0050_0093);
    chk1("seq0_valid", if_id_valid, 1'b1);
    chk32("seq0_pc", if_id_pc, 32'h0);
    chk32("seq0_pc4", if_id_pc4, 32'h4);
    chk32("seq0_inst", if_id_inst, 32'h0050_0093);
    cycle(0, 0, 0, 1, 32'h00A0_0113);
    chk32("seq1_pc", if_id_pc, 32'h4);
    chk32("seq1_pc4", if_id_pc4, 32'h8);
    chk32("seq1_inst", if_id_inst, 32'h00A0_0113);
    chk32("seq1_next_addr", imem_addr, 32'h8);
    $display("txn seq pc=%08h inst=%08h", if_id_pc, if_id_inst);

    // Slow memory on address 8
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, 0, 32'hDEAD_BEEF);
      chk32("wait_addr", imem_addr, 32'h8);
      chk32("wait_ifid_pc", if_id_pc, 32'h4);
    end
    cycle(0, 0, 0, 1, 32'h1111_1111);
    chk32("late_pc", if_id_pc, 32'h8);
    chk32("late_inst", if_id_inst, 32'h1111_1111);
    $display("txn delayed_ack pc=%08h", if_id_pc);

    // Stall while address 12 returns
    cycle(1, 0, 0, 1, 32'h2222_2222);
    chk1("hold_req", imem_req, 1'b0);
    chk32("hold_pc", if_id_pc, 32'h8);
    cycle(1, 0, 0, 0, 32'h0);
    chk1("hold2_req", imem_req, 1'b0);
    chk32("hold2_pc", if_id_pc, 32'h8);
    cycle(0, 0, 0, 0, 32'h0);
    chk32("unhold_pc", if_id_pc, 32'hC);
    chk32("unhold_inst", if_id_inst, 32'h2222_2222);
    chk32("unhold_addr", imem_addr, 32'h10);
    $display("txn stall_hold pc=%08h", if_id_pc);

    // Redirect with request at 16 still pending
    cycle(0, 1, 32'h100, 0, 32'h0);
    chk1("redir_valid", if_id_valid, 1'b0);
    chk32("redir_inst", if_id_inst, NOP);
    chk1("redir_req", imem_req, 1'b1);
    chk32("redir_old_addr", imem_addr, 32'h10);
    cycle(0, 0, 0, 1, 32'h3333_3333);
    chk1("drop_valid", if_id_valid, 1'b0);
    chk32("drop_addr", imem_addr, 32'h100);
    cycle(0, 0, 0, 1, 32'h4444_4444);
    chk32("tgt_pc", if_id_pc, 32'h100);
    chk32("tgt_inst", if_id_inst, 32'h4444_4444);
    chk32("tgt_next", imem_addr, 32'h104);
    $display("txn redirect pc=%08h", if_id_pc);

    // Misaligned redirect wins over stall
    cycle(1, 1, 32'h202, 1, 32'h5555_5555);
    chk1("mis_pulse", misaligned, 1'b1);
    chk32("mis_addr", imem_addr, 32'h200);
    chk1("mis_valid", if_id_valid, 1'b0);
    cycle(0, 0, 0, 0, 32'h0);
    chk1("mis_clear", misaligned, 1'b0);
    $display("txn misaligned addr=%08h", imem_addr);

    // Wrap at top of address space
    cycle(0, 1, 32'hFFFF_FFFC, 1, 32'h0);
    chk32("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    cycle(0, 0, 0, 1, 32'h6666_6666);
    chk32("wrap_pc", if_id_pc, 32'hFFFF_FFFC);
    chk32("wrap_pc4", if_id_pc4, 32'h0);
    chk32("wrap_next", imem_addr, 32'h0);
    $display("txn wrap pc4=%08h", if_id_pc4);

    // Redirect while holding
    cycle(1, 0, 0, 1, 32'h7777_7777);
    chk1("hold3_req", imem_req, 1'b0);
    cycle(1, 1, 32'h40, 0, 32'h0);
    chk1("hredir_valid", if_id_valid, 1'b0);
    chk1("hredir_req", imem_req, 1'b1);
    chk32("hredir_addr", imem_addr, 32'h40);

    // Asynchronous reset mid-request, with a late acknowledge afterwards
    cycle(0, 0, 0, 0, 32'h0);
    @(negedge clk);
    #1;
    imem_ack   = 1'b1;
    imem_rdata = 32'h8888_8888;
    rst        = 1'b1;
    #1;
    chk1("arst_req", imem_req, 1'b0);
    chk1("arst_valid", if_id_valid, 1'b0);
    chk32("arst_inst", if_id_inst, NOP);
    @(negedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk1("post_rst_valid", if_id_valid, 1'b0);
    chk1("post_rst_req", imem_req, 1'b1);
    chk32("post_rst_addr", imem_addr, 32'h0);
    cycle(0, 0, 0, 1, 32'h9999_9999);
    chk32("post_rst_pc", if_id_pc, 32'h0);
    chk32("post_rst_inst", if_id_inst, 32'h9999_9999);
    $display("txn async_reset pc=%08h inst=%08h", if_id_pc, if_id_inst);

    // Randomized traffic
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      #1;
      stall          = ($urandom_range(0, 3) == 0);
      redirect_valid = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 3) == 0)
        redirect_pc = 32'hFFFF_FFF0 | ($urandom() & 32'hF);
      else
        redirect_pc = $urandom();
      imem_ack   = imem_req ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 9) == 0);
      imem_rdata = $urandom();
      if ($urandom_range(0, 399) == 0) begin
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        rst = 1'b0;
      end
    end
    repeat (2) @(posedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
